// File: rtl/divider32bu.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
// Latency: 33 edges from the capture edge to finish (2 edges for a zero divisor).
// Handshake: start is sampled only in IDLE; busy covers capture..DONE; finish pulses for one cycle.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   a, b            dividend and divisor (unsigned), captured on start in IDLE
//   start           request pulse (or held high for back-to-back operation)
//   q, r            registered quotient / remainder, held until the next capture
//   finish          one-cycle pulse while q/r are freshly valid
//   busy            high from the capture edge until finish deasserts
//   dz              divide-by-zero flag, valid with finish
module divider32bu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        finish,
    output logic        busy,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] qreg;      // dividend in, quotient bits shifted in from the LSB
    logic [31:0] breg;      // divisor
    logic [31:0] rem;       // partial remainder; always < divisor, so 32 bits hold it
    logic [5:0]  cnt;       // iteration counter

    logic [32:0] rem_sh;    // shifted remainder needs the 33rd bit before the subtract
    logic [32:0] trial;
    logic [31:0] rem_nxt;
    logic [31:0] qreg_nxt;
    logic        last_iter;
    logic        div_zero;

    // One restoring step. When the trial goes negative, rem_sh < divisor,
    // so its bit 32 is zero and nothing is lost by keeping only 32 bits.
    always_comb begin
        rem_sh    = {rem, qreg[31]};
        trial     = rem_sh - {1'b0, breg};
        rem_nxt   = trial[32] ? rem_sh[31:0] : trial[31:0];
        qreg_nxt  = {qreg[30:0], ~trial[32]};
        last_iter = (cnt == 6'd31);
        div_zero  = (breg == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero divisor still spends one CALC cycle: that cycle detects the zero
    // and loads the fixed result, putting DONE one cycle after capture.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (div_zero || last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            qreg   <= 32'd0;
            breg   <= 32'd0;
            rem    <= 32'd0;
            cnt    <= 6'd0;
            q      <= 32'd0;
            r      <= 32'd0;
            dz     <= 1'b0;
            finish <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    finish <= 1'b0;
                    if (start) begin
                        qreg <= a;
                        breg <= b;
                        rem  <= 32'd0;
                        cnt  <= 6'd0;
                        q    <= 32'd0;
                        r    <= 32'd0;
                        dz   <= 1'b0;
                    end
                end
                CALC: begin
                    if (div_zero) begin
                        // qreg still holds the untouched dividend here
                        q      <= 32'hFFFF_FFFF;
                        r      <= qreg;
                        dz     <= 1'b1;
                        finish <= 1'b1;
                    end else begin
                        qreg <= qreg_nxt;
                        rem  <= rem_nxt;
                        cnt  <= cnt + 6'd1;
                        if (last_iter) begin
                            q      <= qreg_nxt;
                            r      <= rem_nxt;
                            finish <= 1'b1;
                        end
                    end
                end
                default: begin
                    finish <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider32bu.sv
module tb_divider32bu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [31:0] q;
    logic [31:0] r;
    logic        finish;
    logic        busy;
    logic        dz;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    divider32bu dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .start  (start),
        .q      (q),
        .r      (r),
        .finish (finish),
        .busy   (busy),
        .dz     (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb);
        exp_t e;
        if (bb == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = aa;
            e.dz = 1'b1;
        end else begin
            e.q  = aa / bb;
            e.r  = aa % bb;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start and record the expected result; returns just after the capture edge.
    task automatic launch(input logic [31:0] aa, input logic [31:0] bb);
        a     = aa;
        b     = bb;
        start = 1'b1;
        sb.push_back(model(aa, bb));
        tick();
        start = 1'b0;
    endtask

    // Edges until finish is seen, or -1 if it never comes within the budget.
    task automatic wait_finish(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (finish === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.q  = 32'hDEAD_BEEF;
            e.r  = 32'hDEAD_BEEF;
            e.dz = 1'bx;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({q, r, finish, busy, dz} !== 67'd0) begin
            bad++;
            $display("FAIL reset: q=%h r=%h finish=%b busy=%b dz=%b want all zero", q, r, finish, busy, dz);
        end
        tick();
        total++;
        if (busy !== 1'b0 || finish !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b finish=%b want 0 0", busy, finish);
        end
    endtask

    task automatic test_basic();
        int   n;
        exp_t e;
        launch(32'h1F89, 32'h17);
        total++;
        if (busy !== 1'b1 || q !== 32'd0) begin
            bad++;
            $display("FAIL basic_capture: busy=%b q=%h want 1 0", busy, q);
        end
        wait_finish(n);
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL basic_latency: got %0d edges after capture want 32", n);
        end
        pop_exp(e);
        total++;
        if (q !== e.q || r !== e.r || dz !== e.dz) begin
            bad++;
            $display("FAIL basic_result: q=%h r=%h dz=%b want %h %h %b", q, r, dz, e.q, e.r, e.dz);
        end
        tick();
        total++;
        if (finish !== 1'b0 || busy !== 1'b0 || q !== e.q || r !== e.r) begin
            bad++;
            $display("FAIL basic_after: finish=%b busy=%b q=%h r=%h want 0 0 %h %h", finish, busy, q, r, e.q, e.r);
        end
    endtask

    task automatic test_operands();
        logic [31:0] ta [5] = '{32'h140, 32'd100, 32'hFFFF_FFFF, 32'd5, 32'd0};
        logic [31:0] tb [5] = '{32'd32, 32'd7, 32'd1, 32'hFFFF_FFFF, 32'd9};
        int   n;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            launch(ta[i], tb[i]);
            wait_finish(n);
            pop_exp(e);
            total++;
            if (n !== 32 || q !== e.q || r !== e.r || dz !== e.dz) begin
                bad++;
                $display("FAIL operands_%0d: a=%h b=%h lat=%0d q=%h r=%h dz=%b want lat=32 q=%h r=%h dz=%b",
                         i, ta[i], tb[i], n, q, r, dz, e.q, e.r, e.dz);
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int   n;
        exp_t e;
        launch(32'd1234, 32'd0);
        wait_finish(n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL dz_latency: got %0d edges after capture want 1", n);
        end
        pop_exp(e);
        total++;
        if (q !== e.q || r !== e.r || dz !== e.dz) begin
            bad++;
            $display("FAIL dz_result: q=%h r=%h dz=%b want %h %h %b", q, r, dz, e.q, e.r, e.dz);
        end
        tick();
        launch(32'd50, 32'd7);
        total++;
        if (dz !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
            bad++;
            $display("FAIL dz_clear: dz=%b q=%h r=%h after capture want 0 0 0", dz, q, r);
        end
        wait_finish(n);
        pop_exp(e);
        total++;
        if (n !== 32 || q !== e.q || r !== e.r || dz !== e.dz) begin
            bad++;
            $display("FAIL dz_next: lat=%0d q=%h r=%h dz=%b want 32 %h %h %b", n, q, r, dz, e.q, e.r, e.dz);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int   n;
        exp_t e;
        launch(32'd1000, 32'd9);
        repeat (10) tick();
        a = 32'd5; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        a = 32'hFFFF_0000; b = 32'd3;
        wait_finish(n);
        pop_exp(e);
        total++;
        if (n !== 21 || q !== e.q || r !== e.r || dz !== e.dz) begin
            bad++;
            $display("FAIL busy_ignore: lat=%0d q=%h r=%h dz=%b want 21 %h %h %b", n, q, r, dz, e.q, e.r, e.dz);
        end
        tick();
        total++;
        if (busy !== 1'b0 || sb.size() !== 0) begin
            bad++;
            $display("FAIL busy_ignore_idle: busy=%b pending=%0d want 0 0", busy, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [3] = '{32'd600, 32'd1000000, 32'd7};
        logic [31:0] tb [3] = '{32'd25, 32'd999, 32'd8};
        int   n;
        int   t_prev;
        exp_t e;
        t_prev = 0;
        a = ta[0]; b = tb[0]; start = 1'b1;
        sb.push_back(model(ta[0], tb[0]));
        for (int k = 0; k < 3; k++) begin
            wait_finish(n);
            pop_exp(e);
            total++;
            if (n < 0 || q !== e.q || r !== e.r || dz !== e.dz) begin
                bad++;
                $display("FAIL b2b_result_%0d: lat=%0d q=%h r=%h dz=%b want %h %h %b", k, n, q, r, dz, e.q, e.r, e.dz);
            end
            if (k > 0) begin
                total++;
                if (cyc - t_prev !== 34) begin
                    bad++;
                    $display("FAIL b2b_period_%0d: got %0d cycles between finish pulses want 34", k, cyc - t_prev);
                end
            end
            t_prev = cyc;
            if (k < 2) begin
                a = ta[k + 1]; b = tb[k + 1];
                sb.push_back(model(ta[k + 1], tb[k + 1]));
            end else begin
                start = 1'b0;
            end
        end
        tick(); tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stop: busy=%b after start dropped want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int   n;
        exp_t e;
        launch(32'd77, 32'd3);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        total++;
        if (busy !== 1'b0 || q !== 32'd0 || r !== 32'd0 || finish !== 1'b0 || dz !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b q=%h r=%h finish=%b dz=%b want all zero", busy, q, r, finish, dz);
        end
        wait_finish(n);
        total++;
        if (n !== -1) begin
            bad++;
            $display("FAIL mid_reset_nofinish: finish seen %0d edges after reset want none", n);
        end
        launch(32'd77, 32'd3);
        wait_finish(n);
        pop_exp(e);
        total++;
        if (n !== 32 || q !== e.q || r !== e.r || dz !== e.dz) begin
            bad++;
            $display("FAIL mid_reset_fresh: lat=%0d q=%h r=%h dz=%b want 32 %h %h %b", n, q, r, dz, e.q, e.r, e.dz);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        test_reset();
        test_basic();
        test_operands();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
